node_sched: RTL
===============

# node_sched

Round-robin scheduler that shares one LIF `block` tile among several requesters. Each requester presents a bundle of four 4-bit synaptic inputs. The scheduler grants one requester at a time and drives its bundle onto the tile's `in1..in4`. It waits a programmable settle time plus the tile's `rdy`, captures the tile's 4-bit `out`, and returns it to the granted requester with a one-cycle response pulse. Instances sit between the IO fabric and a single `block`, so fewer neuron tiles are needed than logical inputs.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WAIT_CYC`, default 2: settle cycles after issue before `node_rdy` is examined, 0..15.
- `TIMEOUT`, default 15: cycles to wait for `node_rdy` after settle before forcing a capture, 1..255.

- `clk`  in  1: clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req`  in  NREQ: request per requester. Level; held until the matching `resp_valid`.
- `req_data`  in  NREQ*16: bundle for requester i in bits [16i+15:16i]; nibbles map to in1 (LSB) through in4.
- `gnt`  out  NREQ: one-hot grant, high for the whole service.
- `resp_valid`  out  NREQ: one-cycle pulse on the served requester's bit.
- `resp_data`  out  4: captured `node_out`; valid while `resp_valid` is nonzero, held otherwise.
- `resp_err`  out  1: pulses together with `resp_valid` when the capture was forced by timeout.
- `busy`  out  1: high in every state except IDLE.
- `node_in1`..`node_in4`  out  4 each: drive the tile inputs.
- `node_out`  in  4: tile output.
- `node_rdy`  in  1: tile ready, sampled on the rising edge.

## Operation
- States: IDLE, WAIT, SETTLED.
- Reset: all outputs become 0, state becomes IDLE, and the round-robin pointer `last` becomes NREQ-1, so requester 0 has first priority.
- IDLE:
  - `node_in*` are held at 0, so the tile sees no stimulus and leaks.
  - If any `req` bit is set, the winner is the first set bit scanning from `last+1` upward, modulo NREQ.
  - On that edge: `gnt` goes one-hot on the winner, `node_in*` load the winner's bundle, `cnt` loads WAIT_CYC, and the state becomes WAIT.
- WAIT:
  - If `cnt` is nonzero, decrement it.
  - If `cnt` is 0, go to SETTLED and clear `tcnt`.
  - With WAIT_CYC=0, WAIT lasts exactly one cycle.
- SETTLED:
  - If `node_rdy`=1: capture `resp_data` from `node_out`, pulse `resp_valid`, keep `resp_err`=0.
  - Else if `tcnt`=TIMEOUT-1: capture anyway and pulse `resp_valid` with `resp_err`=1.
  - Otherwise increment `tcnt` and stay.
  - On either capture: `gnt` goes to 0, `node_in*` go to 0, `last` takes the winner index, and the state returns to IDLE.
- The bundle is latched at grant time. Changes to `req_data` during service are ignored.
- If a requester drops `req` mid-service, the service still completes and its `resp_valid` still pulses.
- Requests arriving outside IDLE wait. There is no preemption.
- Reset asserted mid-service aborts it: no `resp_valid`, all outputs return to their reset values the next cycle.

## Timing
- Take edge E0 as the edge at which IDLE samples `req` and grants. `gnt` and `node_in*` are valid after E0.
- WAIT occupies edges E1 through E(WAIT_CYC+1).
- The first SETTLED evaluation happens at E(WAIT_CYC+2). With `node_rdy` high there, `resp_valid` is high after that edge: WAIT_CYC+2 cycles after grant, 4 cycles with defaults.
- The worst case adds TIMEOUT-1 cycles.
- Back-to-back requests: one IDLE cycle between the falling `gnt` of one service and the rising `gnt` of the next, giving a service period of WAIT_CYC+3 cycles.
- `resp_valid` is high exactly one cycle per service. `gnt` and `resp_valid` never overlap.

## Test plan
- Single request, defaults:
  - Stimulus: after reset, req=0001, req_data[15:0]=0x4321, node_rdy=1, node_out=0xA.
  - Required: gnt=0001 and node_in1..4 = 1,2,3,4 one cycle later; resp_valid=0001 with resp_data=0xA four cycles after grant; resp_err=0.
- Round-robin fairness:
  - Stimulus: req=1111 held, node_rdy=1.
  - Required: grant order 0,1,2,3,0; consecutive grants 5 cycles apart.
- Timeout:
  - Stimulus: req=0100, node_rdy=0 throughout, node_out=0x7.
  - Required: resp_valid=0100, resp_data=0x7, resp_err=1, with WAIT_CYC+2+TIMEOUT-1 = 18 cycles from grant to response.
- Data latch and request withdrawal:
  - Stimulus: grant requester 1, then change req_data and drop req[1] during WAIT.
  - Required: node_in* keep the originally latched bundle; resp_valid[1] still pulses.
- Reset mid-service:
  - Stimulus: assert rst_n=0 in SETTLED.
  - Required: after the next edge all outputs are 0 and no resp_valid appears; after release, req=1000 is granted as requester 3 (pointer reset).
- WAIT_CYC=0 build:
  - Stimulus: single request with node_rdy=1.
  - Required: resp_valid two cycles after grant.

Source files
------------

// File: rtl/node_sched.sv
// node_sched: round-robin scheduler sharing one LIF block tile among NREQ
// requesters. A granted requester's 16-bit bundle is latched and driven onto
// the tile inputs; after WAIT_CYC settle cycles the tile's rdy (or a timeout)
// triggers capture of node_out, which is returned with a one-cycle pulse.
//
// Handshake: req[i] is a level held by requester i until resp_valid[i]
// pulses. gnt[i] is high for the whole service of requester i, and
// resp_valid[i] is high for exactly one cycle, the cycle after gnt[i] falls.
// gnt and resp_valid never overlap. resp_data/resp_err are meaningful only
// while resp_valid is nonzero; resp_data holds its last value otherwise.
module node_sched #(
  parameter int NREQ     = 4,
  parameter int WAIT_CYC = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*16-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    resp_valid,
  output logic [3:0]         resp_data,
  output logic               resp_err,
  output logic               busy,
  output logic [3:0]         node_in1,
  output logic [3:0]         node_in2,
  output logic [3:0]         node_in3,
  output logic [3:0]         node_in4,
  input  logic [3:0]         node_out,
  input  logic               node_rdy,
  output logic [1:0]         dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_SETTLED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      tcnt_q, tcnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [3:0]      resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic [15:0]     node_in_q, node_in_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   scan_idx;
  logic [15:0]     pick_bundle;

  // Round-robin pick: first set req bit scanning upward from last+1, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IW'((int'(last_q) + k) % NREQ);
      if (!pick_valid && req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Select the winner's bundle from the flat req_data bus.
  always_comb begin
    pick_bundle = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) pick_bundle = req_data[16*i +: 16];
    end
  end

  // Next-state and output logic for the IDLE -> WAIT -> SETTLED service cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    last_d       = last_q;
    win_d        = win_q;
    gnt_d        = gnt_q;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    resp_data_d  = resp_data_q;
    node_in_d    = node_in_q;
    case (state_q)
      S_IDLE: begin
        node_in_d = '0;
        if (pick_valid) begin
          gnt_d     = NREQ'(1) << pick_idx;
          win_d     = pick_idx;
          node_in_d = pick_bundle;
          cnt_d     = 4'(WAIT_CYC);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          tcnt_d  = 8'd0;
          state_d = S_SETTLED;
        end
      end
      S_SETTLED: begin
        if (node_rdy || (tcnt_q == 8'(TIMEOUT - 1))) begin
          resp_valid_d = NREQ'(1) << win_q;
          resp_err_d   = ~node_rdy;
          resp_data_d  = node_out;
          gnt_d        = '0;
          node_in_d    = '0;
          last_d       = win_q;
          state_d      = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: begin
        gnt_d     = '0;
        node_in_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State register; synchronous active-low reset aborts any service in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      last_q       <= IW'(NREQ - 1);
      win_q        <= '0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      node_in_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      last_q       <= last_d;
      win_q        <= win_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      node_in_q    <= node_in_d;
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != S_IDLE);
  assign node_in1   = node_in_q[3:0];
  assign node_in2   = node_in_q[7:4];
  assign node_in3   = node_in_q[11:8];
  assign node_in4   = node_in_q[15:12];
  assign dbg_state  = state_q;

endmodule
